// File: rtl/i2c_byte_rx_if.sv
// i2c_byte_rx_if: bus-side and protocol-side signals of the I2C byte receiver
interface i2c_byte_rx_if #(parameter int DATA_W = 8);
    logic scl_in, sda_in, scl_pos, scl_neg, sda_pos, sda_neg, ack_en;
    logic start_det, stop_det, rx_valid, sda_oe, busy;
    logic [DATA_W-1:0] rx_data;
    modport master (
        output scl_in, sda_in, scl_pos, scl_neg, sda_pos, sda_neg, ack_en,
        input  start_det, stop_det, rx_data, rx_valid, sda_oe, busy
    );
    modport slave (
        input  scl_in, sda_in, scl_pos, scl_neg, sda_pos, sda_neg, ack_en,
        output start_det, stop_det, rx_data, rx_valid, sda_oe, busy
    );
endinterface

// File: rtl/i2c_byte_rx.sv
// i2c_byte_rx: START/STOP detection, MSB-first byte shift-in and 9th-bit ACK drive
module i2c_byte_rx #(parameter int DATA_W = 8) (
    input logic clk,
    input logic rst_n,
    i2c_byte_rx_if.slave bus
);
    localparam int CW = $clog2(DATA_W) + 1;
    typedef enum logic [2:0] {IDLE, RECV, ACK_WAIT, ACK, NACK} state_t;
    state_t state, state_n;
    logic [CW-1:0] bit_cnt, cnt_n;
    logic [DATA_W-1:0] shift, shift_n, data_q, data_n, shifted;
    logic valid_q, valid_n, start_q, start_n, stop_q, stop_n, oe_q, oe_n;
    logic start_c, stop_c;
    // an SDA edge coinciding with an SCL rise is a data change, not a condition
    assign start_c = bus.sda_neg & bus.scl_in & ~bus.scl_pos;
    assign stop_c  = bus.sda_pos & bus.scl_in & ~bus.scl_pos;
    assign shifted = {shift[DATA_W-2:0], bus.sda_in};
    always_comb begin
        state_n = state;
        cnt_n   = bit_cnt;
        shift_n = shift;
        data_n  = data_q;
        valid_n = 1'b0;
        start_n = 1'b0;
        stop_n  = 1'b0;
        oe_n    = oe_q;
        if (stop_c) begin
            state_n = IDLE;
            oe_n    = 1'b0;
            stop_n  = 1'b1;
        end else if (start_c) begin
            state_n = RECV;
            cnt_n   = '0;
            oe_n    = 1'b0;
            start_n = 1'b1;
        end else begin
            case (state)
                RECV: if (bus.scl_pos) begin
                    shift_n = shifted;
                    cnt_n   = bit_cnt + 1'b1;
                    if (bit_cnt == CW'(DATA_W - 1)) begin
                        data_n  = shifted;
                        valid_n = 1'b1;
                        state_n = ACK_WAIT;
                    end
                end
                ACK_WAIT: if (bus.scl_neg) begin
                    oe_n    = bus.ack_en;
                    state_n = bus.ack_en ? ACK : NACK;
                end
                ACK, NACK: if (bus.scl_neg) begin
                    oe_n    = 1'b0;
                    cnt_n   = '0;
                    state_n = RECV;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= cnt_n;
            shift   <= shift_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            start_q <= start_n;
            stop_q  <= stop_n;
            oe_q    <= oe_n;
        end
    end
    assign bus.start_det = start_q;
    assign bus.stop_det  = stop_q;
    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.sda_oe    = oe_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_i2c_byte_rx.sv
// tb_i2c_byte_rx: directed I2C bus stimulus with a byte scoreboard and condition-pulse counters
module tb_i2c_byte_rx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    i2c_byte_rx_if #(.DATA_W(8)) bus();
    i2c_byte_rx #(.DATA_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    logic scl = 1'b1, sda = 1'b1, ack = 1'b0;
    logic scl_q = 1'b1, scl_d = 1'b1, sda_q = 1'b1, sda_d = 1'b1, pos_seen = 1'b0;
    always @(posedge clk) begin
        scl_q <= scl;
        scl_d <= scl_q;
        sda_q <= sda & ~bus.sda_oe;
        sda_d <= sda_q;
        pos_seen <= bus.scl_pos;
    end
    assign bus.scl_in  = scl_q;
    assign bus.sda_in  = sda_q;
    assign bus.scl_pos = scl_q & ~scl_d;
    assign bus.scl_neg = ~scl_q & scl_d;
    assign bus.sda_pos = sda_q & ~sda_d;
    assign bus.sda_neg = ~sda_q & sda_d;
    assign bus.ack_en  = ack;
    int passed = 0, total = 0, n_start = 0, n_stop = 0;
    logic [7:0] exp_q[$];
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    always @(negedge clk) begin
        if (bus.start_det) n_start++;
        if (bus.stop_det) n_stop++;
        if (bus.rx_valid) begin
            chk("rx_valid latency", pos_seen, 1);
            if (exp_q.size() == 0) chk("unexpected rx_valid", 1, 0);
            else chk("rx_data", bus.rx_data, exp_q.pop_front());
        end
    end
    task automatic w(int n);
        repeat (n) @(negedge clk);
        #1;
    endtask
    task automatic start_cond();
        sda = 1'b1; w(2); scl = 1'b1; w(3); sda = 1'b0; w(3); scl = 1'b0; w(2);
    endtask
    task automatic stop_cond();
        sda = 1'b0; w(2); scl = 1'b1; w(3); sda = 1'b1; w(3);
    endtask
    task automatic send_bit(logic b);
        sda = b; w(2); scl = 1'b1; w(4); scl = 1'b0; w(2);
    endtask
    task automatic send_byte(logic [7:0] v, logic a);
        ack = a;
        exp_q.push_back(v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
        sda = 1'b1; w(1);
        chk("sda_oe after 8th fall", bus.sda_oe, a);
        scl = 1'b1; w(3);
        chk("sda line in ack slot", bus.sda_in, !a);
        chk("sda_oe in ack high", bus.sda_oe, a);
        scl = 1'b0; w(3);
        chk("sda_oe after 9th fall", bus.sda_oe, 0);
    endtask
    initial begin
        int s0, p0;
        w(3);
        chk("reset start_det", bus.start_det, 0);
        chk("reset stop_det", bus.stop_det, 0);
        chk("reset rx_data", bus.rx_data, 0);
        chk("reset rx_valid", bus.rx_valid, 0);
        chk("reset sda_oe", bus.sda_oe, 0);
        chk("reset busy", bus.busy, 0);
        rst_n = 1'b1; w(2);
        start_cond();
        chk("first start count", n_start, 1);
        chk("busy after start", bus.busy, 1);
        chk("sda_oe after start", bus.sda_oe, 0);
        send_byte(8'hA5, 1'b1);
        start_cond();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b1);
        s0 = n_start;
        start_cond();
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        start_cond();
        send_byte(8'hFF, 1'b1);
        chk("repeated start count", n_start, s0 + 2);
        chk("rx_data held FF", bus.rx_data, 8'hFF);
        stop_cond();
        chk("stop count", n_stop, 1);
        chk("busy after stop", bus.busy, 0);
        scl = 1'b0; w(2);
        for (int i = 0; i < 9; i++) send_bit(i[0]);
        sda = 1'b1; w(2); scl = 1'b1; w(3);
        chk("busy idle after scl pulses", bus.busy, 0);
        s0 = n_start; p0 = n_stop;
        scl = 1'b0; w(2);
        scl = 1'b1; sda = 1'b0; w(3);
        chk("no start on sda fall with scl rise", n_start, s0);
        scl = 1'b0; w(2);
        scl = 1'b1; sda = 1'b1; w(3);
        chk("no stop on sda rise with scl rise", n_stop, p0);
        chk("busy after coincident edges", bus.busy, 0);
        start_cond();
        ack = 1'b1;
        exp_q.push_back(8'h5A);
        for (int i = 7; i >= 0; i--) send_bit(i[0] ^ (i > 3));
        sda = 1'b1; w(2);
        chk("sda_oe before reset", bus.sda_oe, 1);
        scl = 1'b1; w(1);
        #1 rst_n = 1'b0;
        #1;
        chk("sda_oe async release", bus.sda_oe, 0);
        chk("busy async reset", bus.busy, 0);
        chk("rx_data async reset", bus.rx_data, 0);
        w(3); rst_n = 1'b1; w(3);
        chk("scoreboard drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/i2c_byte_rx.md
Name: i2c_byte_rx

Overview:
- Bit/byte-level receive stage sitting directly downstream of the SCL and SDA edge detectors in the I2C slave.
- Consumes synchronised SCL/SDA levels plus their one-cycle edge pulses.
- Detects START, repeated START and STOP; shifts in 8 data bits MSB-first; presents each completed byte to the protocol layer.
- Drives the 9th-bit ACK through an open-drain enable.

Parameters:
DATA_W, 8, bits per byte before the ACK slot (fixed at 8 for I2C; parameterised for test only)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
scl_in  input  1  synchronised SCL level (same signal fed to SCL edge detector)
sda_in  input  1  synchronised SDA level (same signal fed to SDA edge detector)
scl_pos  input  1  one-cycle pulse, SCL rose (registered; scl_in already high in pulse cycle)
scl_neg  input  1  one-cycle pulse, SCL fell
sda_pos  input  1  one-cycle pulse, SDA rose
sda_neg  input  1  one-cycle pulse, SDA fell
ack_en  input  1  1 = ACK current byte, 0 = NACK; sampled at the ACK-slot SCL fall
start_det  output  1  one-cycle pulse on START or repeated START
stop_det  output  1  one-cycle pulse on STOP
rx_data  output  DATA_W  last completed byte, held until next completion
rx_valid  output  1  one-cycle pulse, rx_data updated
sda_oe  output  1  1 = pull SDA low (open-drain)
busy  output  1  1 when state != IDLE

Behaviour:
- Clock/reset: all regs on posedge clk, async clear on negedge rst_n.
- Reset values: start_det=0, stop_det=0, rx_data=0, rx_valid=0, sda_oe=0, busy=0, state=IDLE, bit_cnt=0, shift reg=0.
- Bus conditions: START = sda_neg & scl_in & ~scl_pos; STOP = sda_pos & scl_in & ~scl_pos.
  - An SDA edge in the same cycle as scl_pos is treated as a data transition, not a condition.
- Priority per cycle: STOP > START > data events.
- States: IDLE, RECV, ACK_WAIT, ACK, NACK.
- Any state, START: go RECV; bit_cnt=0; sda_oe=0; start_det=1 next cycle. Repeated START mid-byte discards partial bits, no rx_valid.
- Any state, STOP: go IDLE; sda_oe=0; stop_det=1 next cycle; partial byte discarded.
- IDLE: ignore scl_pos/scl_neg.
- RECV, on scl_pos:
  - shift reg <= {shift[DATA_W-2:0], sda_in}; bit_cnt++.
  - When bit_cnt reaches DATA_W: rx_data <= shifted value, rx_valid pulses for 1 cycle (registered, 1 cycle after scl_pos pulse), go ACK_WAIT.
- ACK_WAIT, on scl_neg: sample ack_en.
  - ack_en=1: sda_oe=1 (registered, asserted the cycle after scl_neg), go ACK.
  - ack_en=0: sda_oe stays 0, go NACK.
- ACK/NACK, on 9th scl_pos: no shift.
- ACK/NACK, following scl_neg: sda_oe=0; bit_cnt=0; go RECV for next byte.
- SDA edges caused by own sda_oe occur while SCL low, so no false condition.
- bit_cnt width: clog2(DATA_W)+1; never wraps (leaves RECV at DATA_W).
- Reset mid-transfer: all outputs return to reset values immediately; sda_oe released asynchronously.

Test Plan:
- Reset then START (SDA fall, SCL high) -> start_det single pulse, busy=1, sda_oe=0.
- START, bits 1,0,1,0,0,1,0,1, ack_en=1 -> rx_data=8'hA5, rx_valid one pulse after 8th scl_pos; sda_oe=1 from 8th SCL fall through 9th SCL fall, then 0.
- Same byte with ack_en=0 -> rx_data=8'hA5, sda_oe stays 0 through ACK slot, next byte receivable (8'h3C captured correctly).
- START, 4 bits, repeated START, 8 bits of 8'hFF -> no rx_valid for partial byte, start_det twice, rx_data=8'hFF.
- After one byte, STOP (SDA rise, SCL high) -> stop_det pulse, busy=0; further SCL pulses ignored, no rx_valid.
- SDA edge in same cycle as scl_pos, and rst_n low while sda_oe=1 -> no start_det/stop_det; sda_oe drops to 0 without clock edge.
